// File: rtl/decode_dispatch_queue.sv
// In-order dispatch queue at the consumer end of the decode mux.
// Decoded instructions are buffered in a circular buffer. The head entry is
// dispatched when its functional unit reports ready. The queue drives stall
// backpressure and a sticky overflow flag, and supports a synchronous flush.
module decode_dispatch_queue #(
  parameter int addressWidth            = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int regAccessPatternSize    = 2,
  parameter int bodyWidth               = 64,
  parameter int queueDepth              = 8
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            address_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [instMinIdWidth-1:0]          minID_i,
  input  logic [instMinIdWidth-1:0]          numMicroOps_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic [regAccessPatternSize-1:0]    op1rw_i,
  input  logic [regAccessPatternSize-1:0]    op2rw_i,
  input  logic [regAccessPatternSize-1:0]    op3rw_i,
  input  logic [regAccessPatternSize-1:0]    op4rw_i,
  input  logic                               op1IsReg_i,
  input  logic                               op2IsReg_i,
  input  logic                               op3IsReg_i,
  input  logic                               op4IsReg_i,
  input  logic [bodyWidth-1:0]               body_i,
  input  logic [2**funcUnitCodeSize-1:0]     unitReady_i,
  output logic                               stall_o,
  output logic                               overflow_o,
  output logic                               valid_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic [instMinIdWidth-1:0]          numMicroOps_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [regAccessPatternSize-1:0]    op1rw_o,
  output logic [regAccessPatternSize-1:0]    op2rw_o,
  output logic [regAccessPatternSize-1:0]    op3rw_o,
  output logic [regAccessPatternSize-1:0]    op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic [bodyWidth-1:0]               body_o
);

  localparam int PTR_W = $clog2(queueDepth);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [addressWidth-1:0]            address;
    logic [funcUnitCodeSize-1:0]        funcUnitType;
    logic [instructionCounterWidth-1:0] majID;
    logic [instMinIdWidth-1:0]          minID;
    logic [instMinIdWidth-1:0]          numMicroOps;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [regAccessPatternSize-1:0]    op1rw;
    logic [regAccessPatternSize-1:0]    op2rw;
    logic [regAccessPatternSize-1:0]    op3rw;
    logic [regAccessPatternSize-1:0]    op4rw;
    logic                               op1IsReg;
    logic                               op2IsReg;
    logic                               op3IsReg;
    logic                               op4IsReg;
    logic [bodyWidth-1:0]               body;
  } entry_t;

  entry_t                        mem [queueDepth];
  entry_t                        in_entry;
  entry_t                        out_entry_p0;
  logic                          vld_p0;
  logic                          overflow;
  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [CNT_W-1:0]              count;
  logic [funcUnitCodeSize-1:0]   ready_idx;
  logic                          head_ready;
  logic                          full;
  logic                          pop;
  logic                          push;
  logic                          drop;

  // Gather the incoming bundle into one storage word.
  always_comb begin
    in_entry              = '0;
    in_entry.opcode       = opcode_i;
    in_entry.address      = address_i;
    in_entry.funcUnitType = funcUnitType_i;
    in_entry.majID        = majID_i;
    in_entry.minID        = minID_i;
    in_entry.numMicroOps  = numMicroOps_i;
    in_entry.is64Bit      = is64Bit_i;
    in_entry.pid          = pid_i;
    in_entry.tid          = tid_i;
    in_entry.op1rw        = op1rw_i;
    in_entry.op2rw        = op2rw_i;
    in_entry.op3rw        = op3rw_i;
    in_entry.op4rw        = op4rw_i;
    in_entry.op1IsReg     = op1IsReg_i;
    in_entry.op2IsReg     = op2IsReg_i;
    in_entry.op3IsReg     = op3IsReg_i;
    in_entry.op4IsReg     = op4IsReg_i;
    in_entry.body         = body_i;
  end

  // unitReady_i is indexed MSB-first: unit code k lives at bit (2**W-1-k),
  // which is the bitwise complement of k.
  assign ready_idx  = ~mem[head].funcUnitType;
  assign head_ready = unitReady_i[ready_idx];

  // Queue control decisions. A push into a full queue is allowed only when
  // the same edge pops, since the pop frees the slot being written.
  assign full    = (count == CNT_W'(queueDepth));
  assign pop     = !flush_i && (count != '0) && head_ready;
  assign push    = !flush_i && enable_i && (!full || pop);
  assign drop    = !flush_i && enable_i && full && !pop;
  assign stall_o = (count >= CNT_W'(queueDepth - 1));

  // Pointer, occupancy, valid and sticky overflow state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      vld_p0   <= 1'b0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      vld_p0 <= pop;
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clock_i) begin
    if (!reset_i && push) mem[tail] <= in_entry;
  end

  // Dispatch register stage: holds the last dispatched entry between pops.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_entry_p0 <= '0;
    end else if (pop) begin
      out_entry_p0 <= mem[head];
    end
  end

  assign valid_o        = vld_p0;
  assign overflow_o     = overflow;
  assign opcode_o       = out_entry_p0.opcode;
  assign address_o      = out_entry_p0.address;
  assign funcUnitType_o = out_entry_p0.funcUnitType;
  assign majID_o        = out_entry_p0.majID;
  assign minID_o        = out_entry_p0.minID;
  assign numMicroOps_o  = out_entry_p0.numMicroOps;
  assign is64Bit_o      = out_entry_p0.is64Bit;
  assign pid_o          = out_entry_p0.pid;
  assign tid_o          = out_entry_p0.tid;
  assign op1rw_o        = out_entry_p0.op1rw;
  assign op2rw_o        = out_entry_p0.op2rw;
  assign op3rw_o        = out_entry_p0.op3rw;
  assign op4rw_o        = out_entry_p0.op4rw;
  assign op1IsReg_o     = out_entry_p0.op1IsReg;
  assign op2IsReg_o     = out_entry_p0.op2IsReg;
  assign op3IsReg_o     = out_entry_p0.op3IsReg;
  assign op4IsReg_o     = out_entry_p0.op4IsReg;
  assign body_o         = out_entry_p0.body;

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed testbench for decode_dispatch_queue.
module tb_decode_dispatch_queue;

  logic        clock_i = 1'b0;
  logic        reset_i, flush_i, enable_i;
  logic [11:0] opcode_i;
  logic [63:0] address_i;
  logic [2:0]  funcUnitType_i;
  logic [63:0] majID_i;
  logic [6:0]  minID_i, numMicroOps_i;
  logic        is64Bit_i;
  logic [19:0] pid_i;
  logic [15:0] tid_i;
  logic [1:0]  op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic        op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic [63:0] body_i;
  logic [7:0]  unitReady_i;
  logic        stall_o, overflow_o, valid_o;
  logic [11:0] opcode_o;
  logic [63:0] address_o;
  logic [2:0]  funcUnitType_o;
  logic [63:0] majID_o;
  logic [6:0]  minID_o, numMicroOps_o;
  logic        is64Bit_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic        op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [63:0] body_o;

  int tests_run = 0;
  int tests_failed = 0;

  decode_dispatch_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
    .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
    .majID_i(majID_i), .minID_i(minID_i), .numMicroOps_i(numMicroOps_i),
    .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i),
    .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i), .op4rw_i(op4rw_i),
    .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i), .op3IsReg_i(op3IsReg_i),
    .op4IsReg_i(op4IsReg_i), .body_i(body_i), .unitReady_i(unitReady_i),
    .stall_o(stall_o), .overflow_o(overflow_o), .valid_o(valid_o),
    .opcode_o(opcode_o), .address_o(address_o), .funcUnitType_o(funcUnitType_o),
    .majID_o(majID_o), .minID_o(minID_o), .numMicroOps_o(numMicroOps_o),
    .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
    .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
    .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o),
    .op4IsReg_o(op4IsReg_o), .body_o(body_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Present one instruction; side fields are fixed, distinct constants.
  task automatic set_push(input logic [2:0] fu, input logic [63:0] maj,
                          input logic [11:0] op, input logic [63:0] body);
    enable_i       = 1'b1;
    funcUnitType_i = fu;
    majID_i        = maj;
    opcode_i       = op;
    body_i         = body;
    address_i      = 64'hFFFF_0000_0000_1000 + (maj << 2);
    minID_i        = 7'h15;
    numMicroOps_i  = 7'h03;
    is64Bit_i      = 1'b1;
    pid_i          = 20'hABCDE;
    tid_i          = 16'h1234;
    op1rw_i = 2'b01; op2rw_i = 2'b10; op3rw_i = 2'b11; op4rw_i = 2'b00;
    op1IsReg_i = 1'b1; op2IsReg_i = 1'b0; op3IsReg_i = 1'b1; op4IsReg_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    tests_run++; if ({opcode_o, majID_o, body_o} !== '0) begin tests_failed++; $display("FAIL reset_fields: got %h/%h/%h want 0", opcode_o, majID_o, body_o); end
  endtask

  task automatic test_single_fp();
    unitReady_i = 8'b0100_0000;
    set_push(3'd1, 64'd0, 12'd4, 64'h8BE0_1234_5678_9ABC);
    tick(); enable_i = 1'b0;
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL fp_early_valid: got %b want 0", valid_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL fp_valid: got %b want 1", valid_o); end
    tests_run++; if (opcode_o !== 12'd4 || funcUnitType_o !== 3'd1 || majID_o !== 64'd0) begin tests_failed++; $display("FAIL fp_ids: got op=%0d fu=%0d maj=%0d want 4 1 0", opcode_o, funcUnitType_o, majID_o); end
    tests_run++; if (body_o !== 64'h8BE0_1234_5678_9ABC || address_o !== 64'hFFFF_0000_0000_1000) begin tests_failed++; $display("FAIL fp_body_addr: got %h %h", body_o, address_o); end
    tests_run++; if (minID_o !== 7'h15 || numMicroOps_o !== 7'h03 || is64Bit_o !== 1'b1 || pid_o !== 20'hABCDE || tid_o !== 16'h1234) begin tests_failed++; $display("FAIL fp_misc: got %h %h %b %h %h", minID_o, numMicroOps_o, is64Bit_o, pid_o, tid_o); end
    tests_run++; if ({op1rw_o, op2rw_o, op3rw_o, op4rw_o} !== 8'b01_10_11_00 || {op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o} !== 4'b1010) begin tests_failed++; $display("FAIL fp_operands: got %b%b%b%b %b%b%b%b", op1rw_o, op2rw_o, op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL fp_valid_drop: got %b want 0", valid_o); end
    tests_run++; if (opcode_o !== 12'd4) begin tests_failed++; $display("FAIL fp_hold: got %0d want 4", opcode_o); end
  endtask

  task automatic test_fill_overflow();
    unitReady_i = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      set_push(3'd0, 64'(i), 12'(i), 64'(i) * 64'h11);
      tick();
      tests_run++; if (stall_o !== (i >= 7)) begin tests_failed++; $display("FAIL fill_stall_%0d: got %b want %b", i, stall_o, (i >= 7)); end
      tests_run++; if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL fill_overflow_%0d: got %b want 0", i, overflow_o); end
    end
    set_push(3'd0, 64'd100, 12'd100, 64'd100);
    tick(); enable_i = 1'b0;
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL overflow_set: got %b want 1", overflow_o); end
    tick(); tick();
    tests_run++; if (overflow_o !== 1'b1 || valid_o !== 1'b0 || stall_o !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky: got ovf=%b vld=%b stall=%b want 1 0 1", overflow_o, valid_o, stall_o); end
  endtask

  task automatic test_push_pop_full();
    unitReady_i = 8'b1000_0000;
    set_push(3'd0, 64'd9, 12'd9, 64'd9);
    tick(); enable_i = 1'b0;
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd1) begin tests_failed++; $display("FAIL pushpop_first: got vld=%b maj=%0d want 1 1", valid_o, majID_o); end
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL pushpop_stall: got %b want 1", stall_o); end
    for (int i = 2; i <= 9; i++) begin
      tick();
      tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'(i)) begin tests_failed++; $display("FAIL drain_%0d: got vld=%b maj=%0d want 1 %0d", i, valid_o, majID_o, i); end
    end
    tick();
    tests_run++; if (valid_o !== 1'b0 || stall_o !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got vld=%b stall=%b want 0 0", valid_o, stall_o); end
  endtask

  task automatic test_in_order_block();
    unitReady_i = 8'h00;
    set_push(3'd4, 64'd20, 12'd20, 64'd20); tick();
    set_push(3'd0, 64'd21, 12'd21, 64'd21); tick();
    enable_i = 1'b0;
    unitReady_i = 8'b1000_0000;
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL block_1: got %b want 0", valid_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL block_2: got %b want 0", valid_o); end
    unitReady_i = 8'b1000_1000;
    tick();
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd20 || funcUnitType_o !== 3'd4) begin tests_failed++; $display("FAIL block_ls: got vld=%b maj=%0d fu=%0d want 1 20 4", valid_o, majID_o, funcUnitType_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd21 || funcUnitType_o !== 3'd0) begin tests_failed++; $display("FAIL block_fx: got vld=%b maj=%0d fu=%0d want 1 21 0", valid_o, majID_o, funcUnitType_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL block_end: got %b want 0", valid_o); end
  endtask

  task automatic test_flush();
    unitReady_i = 8'h00;
    for (int i = 0; i < 5; i++) begin
      set_push(3'd0, 64'(30 + i), 12'(30 + i), 64'(30 + i)); tick();
    end
    flush_i = 1'b1;
    set_push(3'd0, 64'd35, 12'd35, 64'd35);
    tick(); flush_i = 1'b0; enable_i = 1'b0;
    tests_run++; if (valid_o !== 1'b0 || stall_o !== 1'b0) begin tests_failed++; $display("FAIL flush_state: got vld=%b stall=%b want 0 0", valid_o, stall_o); end
    unitReady_i = 8'b1000_0000;
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_empty: got %b want 0", valid_o); end
    set_push(3'd0, 64'd40, 12'd40, 64'd40); tick();
    set_push(3'd0, 64'd41, 12'd41, 64'd41); tick();
    enable_i = 1'b0;
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd40) begin tests_failed++; $display("FAIL flush_fresh_a: got vld=%b maj=%0d want 1 40", valid_o, majID_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd41) begin tests_failed++; $display("FAIL flush_fresh_b: got vld=%b maj=%0d want 1 41", valid_o, majID_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_fresh_end: got %b want 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    tests_run++; if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_overflow: got %b want 1", overflow_o); end
    unitReady_i = 8'b1000_0000;
    set_push(3'd0, 64'd50, 12'd50, 64'd50); tick();
    set_push(3'd0, 64'd51, 12'd51, 64'd51); tick();
    set_push(3'd0, 64'd52, 12'd52, 64'd52); tick();
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd51) begin tests_failed++; $display("FAIL mid_stream: got vld=%b maj=%0d want 1 51", valid_o, majID_o); end
    reset_i = 1'b1; flush_i = 1'b1;
    set_push(3'd0, 64'd53, 12'd53, 64'd53);
    tick(); reset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0;
    tests_run++; if (valid_o !== 1'b0 || overflow_o !== 1'b0 || stall_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ctrl: got vld=%b ovf=%b stall=%b want 0 0 0", valid_o, overflow_o, stall_o); end
    tests_run++; if ({opcode_o, majID_o, body_o, pid_o} !== '0) begin tests_failed++; $display("FAIL mid_reset_fields: got %h/%h/%h/%h want 0", opcode_o, majID_o, body_o, pid_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_empty: got %b want 0", valid_o); end
    set_push(3'd0, 64'd60, 12'd60, 64'd60); tick();
    enable_i = 1'b0; tick();
    tests_run++; if (valid_o !== 1'b1 || majID_o !== 64'd60) begin tests_failed++; $display("FAIL mid_resume: got vld=%b maj=%0d want 1 60", valid_o, majID_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL mid_resume_end: got %b want 0", valid_o); end
  endtask

  initial begin
    reset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0; unitReady_i = 8'h00;
    set_push(3'd0, 64'd0, 12'd0, 64'd0);
    enable_i = 1'b0;
    test_reset();
    test_single_fp();
    test_fill_overflow();
    test_push_pop_full();
    test_in_order_block();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
